// File: rtl/issue_pkg.sv
// Shared types and opcode constants for the dual-issue pairing stage.
// Optional statistics counters are enabled in the top with ISSUE_STATS_EN.
package issue_pkg;

  // Opcodes that matter to register decode and memory-pair detection
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } issue_state_t;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       wen;
    logic       is_mem;
  } decoded_t;

  // True when the younger word cannot issue alongside the older one:
  // it reads or rewrites the older word's destination, or both touch memory.
  function automatic logic pair_conflict(decoded_t older, decoded_t younger);
    logic raw;
    logic waw;
    logic mem;
    raw = older.wen && ((younger.rs == older.dest) || (younger.rt == older.dest));
    waw = older.wen && younger.wen && (older.dest == younger.dest);
    mem = older.is_mem && younger.is_mem;
    return raw | waw | mem;
  endfunction

endpackage

// File: rtl/issue_pair_if.sv
// Fetch-side and issue-side handshake bundle for issue_pair.
// master = surrounding pipeline (fetch + execute), slave = the issue stage.
interface issue_pair_if;

  logic        flush;
  logic        in_valid_1;
  logic        in_valid_2;
  logic [31:0] in_instr_1;
  logic [31:0] in_instr_2;
  logic        in_ready;
  logic        out_ready;
  logic        out_valid_1;
  logic        out_valid_2;
  logic [31:0] out_instr_1;
  logic [31:0] out_instr_2;
  logic [4:0]  readaddr1_1;
  logic [4:0]  readaddr2_1;
  logic [4:0]  readaddr1_2;
  logic [4:0]  readaddr2_2;
  logic [4:0]  dest_1;
  logic [4:0]  dest_2;
  logic        wen_1;
  logic        wen_2;

  modport master (
    output flush, in_valid_1, in_valid_2, in_instr_1, in_instr_2, out_ready,
    input  in_ready, out_valid_1, out_valid_2, out_instr_1, out_instr_2,
    input  readaddr1_1, readaddr2_1, readaddr1_2, readaddr2_2,
    input  dest_1, dest_2, wen_1, wen_2
  );

  modport slave (
    input  flush, in_valid_1, in_valid_2, in_instr_1, in_instr_2, out_ready,
    output in_ready, out_valid_1, out_valid_2, out_instr_1, out_instr_2,
    output readaddr1_1, readaddr2_1, readaddr1_2, readaddr2_2,
    output dest_1, dest_2, wen_1, wen_2
  );

endinterface

// File: rtl/issue_decode.sv
// Combinational register-field extractor for one 32-bit instruction word.
module issue_decode
  import issue_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [5:0] opcode;
  logic       unused_low_bits;

  assign opcode = instr[31:26];
  // shamt/funct/immediate bits never influence register fields
  assign unused_low_bits = ^instr[10:0];

  // Pick source fields, destination and memory flag from the opcode
  always_comb begin
    logic has_write;
    dec        = '0;
    has_write  = 1'b0;
    dec.rs     = instr[25:21];
    dec.rt     = instr[20:16];
    case (opcode)
      OP_RTYPE: begin
        has_write = 1'b1;
        dec.dest  = instr[15:11];
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
        has_write = 1'b1;
        dec.dest  = instr[20:16];
      end
      default: begin
        has_write = 1'b0;
        dec.dest  = 5'd0;
      end
    endcase
    dec.wen    = has_write && (dec.dest != 5'd0);
    dec.is_mem = (opcode == OP_LW) || (opcode == OP_SW);
  end

endmodule

// File: rtl/issue_pair.sv
// Dual-issue pairing stage: accepts up to two fetched words, splits
// intra-pair RAW/WAW/memory conflicts across two cycles, and registers
// the issue slots feeding the register file and execute stage.
// Define ISSUE_STATS_EN to add the pair_count/split_count counters.
module issue_pair
  import issue_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  issue_pair_if.slave  bus
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0]  pair_count,
  output logic [31:0]  split_count
`endif
);

  decoded_t     dec_1;
  decoded_t     dec_2;
  decoded_t     dec_hold;
  issue_state_t state;
  logic [31:0]  hold_instr;
  logic         split;
  logic         accept;

  issue_decode u_dec_1    (.instr(bus.in_instr_1), .dec(dec_1));
  issue_decode u_dec_2    (.instr(bus.in_instr_2), .dec(dec_2));
  issue_decode u_dec_hold (.instr(hold_instr),     .dec(dec_hold));

  assign split  = bus.in_valid_1 && bus.in_valid_2 && pair_conflict(dec_1, dec_2);
  assign accept = bus.in_valid_1 && bus.in_ready;

  // Fetch may advance only in IDLE, when downstream drains, and not while flushing
  always_comb begin
    bus.in_ready = (state == IDLE) && bus.out_ready && !bus.flush;
  end

  // Pairing FSM with registered issue slots and the split hold register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      hold_instr      <= '0;
      bus.out_valid_1 <= 1'b0;
      bus.out_valid_2 <= 1'b0;
      bus.out_instr_1 <= '0;
      bus.out_instr_2 <= '0;
      bus.readaddr1_1 <= '0;
      bus.readaddr2_1 <= '0;
      bus.readaddr1_2 <= '0;
      bus.readaddr2_2 <= '0;
      bus.dest_1      <= '0;
      bus.dest_2      <= '0;
      bus.wen_1       <= 1'b0;
      bus.wen_2       <= 1'b0;
    end else if (bus.flush) begin
      state           <= IDLE;
      hold_instr      <= '0;
      bus.out_valid_1 <= 1'b0;
      bus.out_valid_2 <= 1'b0;
    end else if (bus.out_ready) begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.out_valid_1 <= 1'b1;
            bus.out_instr_1 <= bus.in_instr_1;
            bus.readaddr1_1 <= dec_1.rs;
            bus.readaddr2_1 <= dec_1.rt;
            bus.dest_1      <= dec_1.dest;
            bus.wen_1       <= dec_1.wen;
            if (split) begin
              bus.out_valid_2 <= 1'b0;
              bus.out_instr_2 <= '0;
              bus.readaddr1_2 <= '0;
              bus.readaddr2_2 <= '0;
              bus.dest_2      <= '0;
              bus.wen_2       <= 1'b0;
              hold_instr      <= bus.in_instr_2;
              state           <= SPLIT;
            end else if (bus.in_valid_2) begin
              bus.out_valid_2 <= 1'b1;
              bus.out_instr_2 <= bus.in_instr_2;
              bus.readaddr1_2 <= dec_2.rs;
              bus.readaddr2_2 <= dec_2.rt;
              bus.dest_2      <= dec_2.dest;
              bus.wen_2       <= dec_2.wen;
            end else begin
              bus.out_valid_2 <= 1'b0;
              bus.out_instr_2 <= '0;
              bus.readaddr1_2 <= '0;
              bus.readaddr2_2 <= '0;
              bus.dest_2      <= '0;
              bus.wen_2       <= 1'b0;
            end
          end else begin
            bus.out_valid_1 <= 1'b0;
            bus.out_valid_2 <= 1'b0;
          end
        end
        SPLIT: begin
          bus.out_valid_1 <= 1'b1;
          bus.out_instr_1 <= hold_instr;
          bus.readaddr1_1 <= dec_hold.rs;
          bus.readaddr2_1 <= dec_hold.rt;
          bus.dest_1      <= dec_hold.dest;
          bus.wen_1       <= dec_hold.wen;
          bus.out_valid_2 <= 1'b0;
          bus.out_instr_2 <= '0;
          bus.readaddr1_2 <= '0;
          bus.readaddr2_2 <= '0;
          bus.dest_2      <= '0;
          bus.wen_2       <= 1'b0;
          hold_instr      <= '0;
          state           <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ISSUE_STATS_EN
  // Count dual-slot issues and split decisions; survive flush, clear on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_count  <= '0;
      split_count <= '0;
    end else begin
      if (accept && !split && bus.in_valid_2) begin
        pair_count <= pair_count + 32'd1;
      end
      if (accept && split) begin
        split_count <= split_count + 32'd1;
      end
    end
  end
`endif

endmodule
